// File: rtl/multi_scanner_ring.sv
// multi_scanner_ring: ring of N_SCAN buffer scanners with pre-wake handoff.
// Define SCAN_STATS_EN to add saturating xfer_total / flush_total outputs.
module multi_scanner_ring #(
    parameter int N_SCAN    = 2,
    parameter int DEPTH     = 10,
    parameter int CNT_W     = 4,
    parameter int STBY_LVL  = 8,
    parameter int START_LVL = 9,
    parameter int DIV_BITS  = 24,
    localparam int IDX_W    = $clog2(N_SCAN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startSystem,
    input  logic                    startScan,
    input  logic                    startTransfer,
    output logic [3*N_SCAN-1:0]     state_bus,
    output logic [CNT_W*N_SCAN-1:0] count_bus,
    output logic [N_SCAN-1:0]       ready_to_transfer,
    output logic [IDX_W-1:0]        active_idx,
    output logic                    clk_led
`ifdef SCAN_STATS_EN
    ,
    output logic [15:0]             xfer_total,
    output logic [15:0]             flush_total
`endif
);

    localparam logic [2:0] LOWPOWER     = 3'b000;
    localparam logic [2:0] STANDBY      = 3'b001;
    localparam logic [2:0] COLLECTING   = 3'b010;
    localparam logic [2:0] IDLE         = 3'b011;
    localparam logic [2:0] TRANSFERRING = 3'b100;
    localparam logic [2:0] FLUSHING     = 3'b101;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_STBY  = CNT_W'(STBY_LVL);
    localparam logic [CNT_W-1:0] C_START = CNT_W'(START_LVL);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);

    logic              tick;
    logic              any_coll;
    logic [N_SCAN-1:0] coll;
    logic [N_SCAN-1:0] wake;
    logic [N_SCAN-1:0] go;
    logic [N_SCAN-1:0] adv;
    logic [N_SCAN-1:0] elig;
    logic [N_SCAN-1:0] take;
    logic [IDX_W-1:0]  idx_n;

    if (DIV_BITS == 0) begin : g_nodiv
        assign tick = 1'b1;
    end else begin : g_div
        logic [DIV_BITS-1:0] div;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) div <= '0;
            else        div <= div + DIV_BITS'(1);
        end
        assign tick = &div;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    clk_led <= 1'b0;
        else if (tick) clk_led <= ~clk_led;
    end

    assign any_coll = |coll;
    // lowest-index IDLE scanner not being flushed wins startTransfer
    assign take = elig & (~elig + N_SCAN'(1));

    for (genvar g = 0; g < N_SCAN; g++) begin : g_scan
        localparam int SUCC = (g + 1) % N_SCAN;
        logic [2:0]       st;
        logic [2:0]       st_n;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic             mine;

        assign mine        = active_idx == IDX_W'(g);
        assign coll[g]     = st == COLLECTING;
        assign wake[SUCC]  = coll[g] && cnt >= C_STBY;
        assign go[SUCC]    = coll[g] && cnt >= C_START;
        assign adv[g]      = coll[g] && cnt == C_DEPTH && coll[SUCC];
        assign elig[g]     = st == IDLE && !go[g];

        assign state_bus[3*g +: 3]         = st;
        assign count_bus[CNT_W*g +: CNT_W] = cnt;
        assign ready_to_transfer[g]        = st == IDLE;

        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            unique case (st)
                LOWPOWER: begin
                    if (go[g])
                        st_n = COLLECTING;
                    else if (wake[g] || (startSystem && mine && !any_coll))
                        st_n = STANDBY;
                end
                STANDBY: begin
                    if (go[g] || (startScan && mine)) st_n = COLLECTING;
                end
                COLLECTING: begin
                    if (cnt != C_DEPTH)   cnt_n = cnt + C_ONE;
                    else if (coll[SUCC])  st_n  = IDLE;
                end
                IDLE: begin
                    if (go[g])                          st_n = FLUSHING;
                    else if (startTransfer && take[g])  st_n = TRANSFERRING;
                end
                TRANSFERRING: begin
                    if (cnt == '0) st_n  = LOWPOWER;
                    else           cnt_n = cnt - C_ONE;
                end
                FLUSHING: begin
                    if (cnt == '0)       st_n  = go[g] ? COLLECTING : LOWPOWER;
                    else if (cnt < C_TWO) cnt_n = '0;
                    else                 cnt_n = cnt - C_TWO;
                end
                default: begin
                    st_n  = LOWPOWER;
                    cnt_n = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st  <= LOWPOWER;
                cnt <= '0;
            end else if (tick) begin
                st  <= st_n;
                cnt <= cnt_n;
            end
        end
    end

    always_comb begin
        idx_n = active_idx;
        for (int i = 0; i < N_SCAN; i++)
            if (adv[i]) idx_n = IDX_W'((i + 1) % N_SCAN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    active_idx <= '0;
        else if (tick) active_idx <= idx_n;
    end

`ifdef SCAN_STATS_EN
    logic [N_SCAN-1:0] xfer_done;
    logic [N_SCAN-1:0] flush_start;

    for (genvar g = 0; g < N_SCAN; g++) begin : g_ev
        assign xfer_done[g]   = g_scan[g].st == TRANSFERRING &&
                                g_scan[g].cnt == '0;
        assign flush_start[g] = g_scan[g].st == IDLE && go[g];
    end

    function automatic logic [15:0] sat_add(input logic [15:0]       a,
                                            input logic [N_SCAN-1:0] ev);
        logic [16:0] s;
        s = {1'b0, a} + 17'($countones(ev));
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_total  <= '0;
            flush_total <= '0;
        end else if (tick) begin
            xfer_total  <= sat_add(xfer_total, xfer_done);
            flush_total <= sat_add(flush_total, flush_start);
        end
    end
`endif

endmodule

// File: tb/tb_multi_scanner_ring.sv
// Bench for multi_scanner_ring: vector table, corner sequences, random vs model.
// Three instances: N_SCAN=2/DIV 0, N_SCAN=3/DIV 0, N_SCAN=2/DIV 2.
`timescale 1ns/1ps
module tb_multi_scanner_ring;

    localparam int LP = 0, SB = 1, CO = 2, ID = 3, TR = 4, FL = 5;
    localparam int DEPTH = 10, STBY = 8, START = 9;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ss    = 1'b0;
    logic sc    = 1'b0;
    logic stx   = 1'b0;

    logic [5:0]  sb0;
    logic [7:0]  cb0;
    logic [1:0]  rdy0;
    logic [0:0]  ai0;
    logic        led0;
    logic [8:0]  sb1;
    logic [11:0] cb1;
    logic [2:0]  rdy1;
    logic [1:0]  ai1;
    logic        led1;
    logic [5:0]  sb2;
    logic [7:0]  cb2;
    logic [1:0]  rdy2;
    logic [0:0]  ai2;
    logic        led2;
`ifdef SCAN_STATS_EN
    logic [15:0] xf0, fl0, xf1, fl1, xf2, fl2;
`endif

    always #5 clk = ~clk;

    multi_scanner_ring #(.N_SCAN(2), .DIV_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .startSystem(ss), .startScan(sc),
        .startTransfer(stx), .state_bus(sb0), .count_bus(cb0),
        .ready_to_transfer(rdy0), .active_idx(ai0), .clk_led(led0)
`ifdef SCAN_STATS_EN
        , .xfer_total(xf0), .flush_total(fl0)
`endif
    );

    multi_scanner_ring #(.N_SCAN(3), .DIV_BITS(0)) dut1 (
        .clk(clk), .reset(reset), .startSystem(ss), .startScan(sc),
        .startTransfer(stx), .state_bus(sb1), .count_bus(cb1),
        .ready_to_transfer(rdy1), .active_idx(ai1), .clk_led(led1)
`ifdef SCAN_STATS_EN
        , .xfer_total(xf1), .flush_total(fl1)
`endif
    );

    multi_scanner_ring #(.N_SCAN(2), .DIV_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .startSystem(ss), .startScan(sc),
        .startTransfer(stx), .state_bus(sb2), .count_bus(cb2),
        .ready_to_transfer(rdy2), .active_idx(ai2), .clk_led(led2)
`ifdef SCAN_STATS_EN
        , .xfer_total(xf2), .flush_total(fl2)
`endif
    );

    int checks = 0;
    int errors = 0;

    int nsc[3]   = '{2, 3, 2};
    int dbits[3] = '{0, 0, 2};
    int m_st[3][3];
    int m_cnt[3][3];
    int m_idx[3];
    int m_led[3];
    int m_div[3];
    int m_xf[3];
    int m_fl[3];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                m_st[k][i]  = LP;
                m_cnt[k][i] = 0;
            end
            m_idx[k] = 0;
            m_led[k] = 0;
            m_div[k] = 0;
            m_xf[k]  = 0;
            m_fl[k]  = 0;
        end
    endtask

    // One clock of the reference: derive ring signals from the old
    // snapshot, then apply the per-state rules to every scanner.
    task automatic model_tick(input int k);
        int  n, oi, tk, p, per;
        int  os[3];
        int  oc[3];
        bit  gq[3];
        bit  wk[3];
        bit  anyc, tick;
        n    = nsc[k];
        per  = 1 << dbits[k];
        tick = (m_div[k] == per - 1);
        m_div[k] = (m_div[k] + 1) % per;
        if (!tick) return;
        m_led[k] = 1 - m_led[k];
        oi   = m_idx[k];
        anyc = 1'b0;
        for (int i = 0; i < n; i++) begin
            os[i] = m_st[k][i];
            oc[i] = m_cnt[k][i];
            if (os[i] == CO) anyc = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            p     = (i + n - 1) % n;
            wk[i] = os[p] == CO && oc[p] >= STBY;
            gq[i] = os[p] == CO && oc[p] >= START;
        end
        tk = -1;
        for (int i = 0; i < n; i++)
            if (tk < 0 && os[i] == ID && !gq[i]) tk = i;
        for (int i = 0; i < n; i++) begin
            case (os[i])
                LP: if (gq[i]) m_st[k][i] = CO;
                    else if (wk[i] || (ss && i == oi && !anyc)) m_st[k][i] = SB;
                SB: if (gq[i] || (sc && i == oi)) m_st[k][i] = CO;
                CO: if (oc[i] < DEPTH) m_cnt[k][i] = oc[i] + 1;
                    else if (os[(i + 1) % n] == CO) begin
                        m_st[k][i] = ID;
                        m_idx[k]   = (i + 1) % n;
                    end
                ID: if (gq[i]) begin
                        m_st[k][i] = FL;
                        if (m_fl[k] < 65535) m_fl[k]++;
                    end else if (stx && tk == i) m_st[k][i] = TR;
                TR: if (oc[i] == 0) begin
                        m_st[k][i] = LP;
                        if (m_xf[k] < 65535) m_xf[k]++;
                    end else m_cnt[k][i] = oc[i] - 1;
                FL: if (oc[i] == 0) m_st[k][i] = gq[i] ? CO : LP;
                    else m_cnt[k][i] = (oc[i] > 2) ? oc[i] - 2 : 0;
                default: ;
            endcase
        end
    endtask

    function automatic longint dut_out(input int k, input int f);
        longint o[5];
        case (k)
            0: o = '{longint'(sb0), longint'(cb0), longint'(rdy0),
                     longint'(ai0), longint'(led0)};
            1: o = '{longint'(sb1), longint'(cb1), longint'(rdy1),
                     longint'(ai1), longint'(led1)};
            default: o = '{longint'(sb2), longint'(cb2), longint'(rdy2),
                           longint'(ai2), longint'(led2)};
        endcase
        return o[f];
    endfunction

    function automatic longint exp_out(input int k, input int f);
        longint v = 0;
        for (int i = 0; i < nsc[k]; i++) begin
            if (f == 0) v |= longint'(m_st[k][i]) << (3 * i);
            if (f == 1) v |= longint'(m_cnt[k][i]) << (4 * i);
            if (f == 2 && m_st[k][i] == ID) v |= longint'(1) << i;
        end
        if (f == 3) v = m_idx[k];
        if (f == 4) v = m_led[k];
        return v;
    endfunction

    task automatic check_all();
        string nm[5] = '{"state_bus", "count_bus", "ready", "active_idx", "clk_led"};
        for (int k = 0; k < 3; k++)
            for (int f = 0; f < 5; f++)
                chk($sformatf("dut%0d %s", k, nm[f]), dut_out(k, f), exp_out(k, f));
`ifdef SCAN_STATS_EN
        chk("dut0 xfer_total", xf0, m_xf[0]);
        chk("dut0 flush_total", fl0, m_fl[0]);
        chk("dut1 xfer_total", xf1, m_xf[1]);
        chk("dut1 flush_total", fl1, m_fl[1]);
        chk("dut2 xfer_total", xf2, m_xf[2]);
        chk("dut2 flush_total", fl2, m_fl[2]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_tick(k);
        #1;
        check_all();
    endtask

    // called at posedge+1: reset lands and is checked before the next edge
    task automatic apply_reset();
        ss  = 1'b0;
        sc  = 1'b0;
        stx = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset state_bus1", sb1, 0);
        chk("reset count_bus1", cb1, 0);
        reset = 1'b1;
    endtask

    typedef struct {
        bit         ss;
        bit         sc;
        bit         stx;
        logic [5:0] sb;
        logic [7:0] cb;
        logic [1:0] rdy;
        logic       ai;
    } vec_t;

    vec_t tbl[15];
    int   w;
    int   aq[$];
    logic [1:0] last_ai;

    initial begin
        tbl[0]  = '{0, 0, 0, 6'h00, 8'h00, 2'b00, 1'b0};
        tbl[1]  = '{1, 0, 0, 6'h01, 8'h00, 2'b00, 1'b0};
        tbl[2]  = '{0, 1, 0, 6'h02, 8'h00, 2'b00, 1'b0};
        for (int r = 3; r <= 10; r++)
            tbl[r] = '{0, 0, 0, 6'h02, 8'(r - 2), 2'b00, 1'b0};
        tbl[11] = '{0, 0, 0, 6'h0A, 8'h09, 2'b00, 1'b0};
        tbl[12] = '{0, 0, 0, 6'h12, 8'h0A, 2'b00, 1'b0};
        tbl[13] = '{0, 0, 0, 6'h13, 8'h1A, 2'b01, 1'b1};
        tbl[14] = '{0, 0, 1, 6'h14, 8'h2A, 2'b00, 1'b1};

        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        chk("reset led0", led0, 0);
        reset = 1'b1;

        for (int r = 0; r < 15; r++) begin
            ss  = tbl[r].ss;
            sc  = tbl[r].sc;
            stx = tbl[r].stx;
            step();
            chk($sformatf("vec%0d state", r), sb0, tbl[r].sb);
            chk($sformatf("vec%0d count", r), cb0, tbl[r].cb);
            chk($sformatf("vec%0d ready", r), rdy0, tbl[r].rdy);
            chk($sformatf("vec%0d idx", r), ai0, tbl[r].ai);
        end
        ss  = 1'b0;
        sc  = 1'b0;
        stx = 1'b0;

        // transfer drains while scanner1 stalls at DEPTH waiting on go[0]
        repeat (10) step();
        chk("xfer end state0", sb0[2:0], TR);
        chk("xfer end count0", cb0[3:0], 0);
        step();
        chk("xfer lowpower0", sb0[2:0], LP);
        chk("xfer ready0", rdy0[0], 0);
        chk("stall state1", sb0[5:3], CO);
        chk("stall count1", cb0[7:4], DEPTH);
        step();
        chk("go after xfer0", sb0[2:0], CO);
        chk("still stalled1", cb0[7:4], DEPTH);
        step();
        chk("stall release1", sb0[5:3], ID);
        chk("stall idx", ai0, 0);
        chk("stall ready", rdy0, 2'b10);

        // untransferred scanner1 is flushed by two per tick
        w = 0;
        while (sb0[5:3] != FL && w < 100) begin
            step();
            w++;
        end
        chk("flush reached", longint'(w < 100), 1);
        chk("flush start count", cb0[7:4], DEPTH);
        for (int j = 1; j <= 5; j++) begin
            step();
            chk($sformatf("flush beat%0d state", j), sb0[5:3], FL);
            chk($sformatf("flush beat%0d count", j), cb0[7:4], DEPTH - 2 * j);
        end
        step();
        chk("flush to collect", sb0[5:3], CO);

        // three-scanner handoff with transfers always requested
        apply_reset();
        ss = 1'b1;
        step();
        ss = 1'b0;
        sc = 1'b1;
        step();
        sc  = 1'b0;
        stx = 1'b1;
        last_ai = ai1;
        w = 0;
        while (aq.size() < 3 && w < 400) begin
            step();
            if (ai1 != last_ai) aq.push_back(int'(ai1));
            last_ai = ai1;
            w++;
        end
        chk("handoff seen", aq.size(), 3);
        if (aq.size() == 3) begin
            chk("handoff 1st", aq[0], 1);
            chk("handoff 2nd", aq[1], 2);
            chk("handoff 3rd", aq[2], 0);
        end

        // reset asserted while a scanner of dut1 is flushing
        apply_reset();
        ss = 1'b1;
        step();
        ss = 1'b0;
        sc = 1'b1;
        step();
        sc = 1'b0;
        w = 0;
        while (sb1[2:0] != FL && sb1[5:3] != FL && sb1[8:6] != FL && w < 200) begin
            step();
            w++;
        end
        chk("n3 flush reached", longint'(w < 200), 1);
        apply_reset();

        for (int c = 0; c < 4000; c++) begin
            if (c % 8 == 0) begin
                ss  = ($urandom_range(0, 3) == 0);
                sc  = $urandom_range(0, 1) != 0;
                stx = ($urandom_range(0, 2) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
